// File: rtl/lzc_seq_ctrl.sv
// Multi-cycle leading-zero counter for a DATA_W*CHUNKS-bit word.
// The word is scanned one DATA_W-bit chunk per cycle, MSB chunk first.
// The scan stops at the first chunk that contains a 1.
// Both the input and the output use a valid/ready handshake.

// Single-chunk leading-zero counter; an all-zero chunk reports DATA_W.
module zero_counter #(
  parameter int DATA_W = 8,
  parameter int ZC_W   = 4
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [ZC_W-1:0]   count_o
);

  logic found;

  // Count zeros from the MSB down until the first set bit.
  always_comb begin
    count_o = '0;
    found   = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (data_i[i]) found = 1'b1;
        else           count_o = count_o + ZC_W'(1);
      end
    end
  end

endmodule

// State | meaning
// IDLE  | waiting for a word; in_ready high
// SCAN  | examining one chunk per cycle, accumulating zero counts
// DONE  | result presented; waiting for out_ready
module lzc_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CHUNKS  = 4,
  parameter int ZC_W    = 4,
  parameter int COUNT_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W*CHUNKS-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COUNT_W-1:0]         out_count,
  output logic                       out_all_zero,
  output logic                       busy
);

  localparam int W     = DATA_W * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [COUNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               out_all_zero_q, out_all_zero_d;

  logic [DATA_W-1:0]  chunk;
  logic [ZC_W-1:0]    zc;
  logic [COUNT_W-1:0] acc_next;
  logic               chunk_hit;
  logic               last_chunk;

  assign chunk = shreg_q[W-1 -: DATA_W];

  zero_counter #(
    .DATA_W (DATA_W),
    .ZC_W   (ZC_W)
  ) u_zc (
    .data_i  (chunk),
    .count_o (zc)
  );

  assign acc_next   = acc_q + COUNT_W'(zc);
  assign chunk_hit  = (zc < ZC_W'(DATA_W));
  assign last_chunk = (idx_q == IDX_W'(CHUNKS - 1));

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = out_valid_q;
  assign out_count    = out_count_q;
  assign out_all_zero = out_all_zero_q;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      acc_q          <= '0;
      idx_q          <= '0;
      out_valid_q    <= 1'b0;
      out_count_q    <= '0;
      out_all_zero_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      out_valid_q    <= out_valid_d;
      out_count_q    <= out_count_d;
      out_all_zero_q <= out_all_zero_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    out_valid_d    = out_valid_q;
    out_count_d    = out_count_q;
    out_all_zero_d = out_all_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_next;
        if (chunk_hit || last_chunk) begin
          out_count_d    = acc_next;
          out_all_zero_d = (acc_next == COUNT_W'(W));
          out_valid_d    = 1'b1;
          state_d        = DONE;
        end else begin
          shreg_d = shreg_q << DATA_W;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lzc_seq_ctrl.sv
// Directed and randomized bench for lzc_seq_ctrl with default parameters.
module tb_lzc_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic        out_all_zero;
  logic        busy;

  int tests;
  int fails;

  lzc_seq_ctrl #(
    .DATA_W  (8),
    .CHUNKS  (4),
    .ZC_W    (4),
    .COUNT_W (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_count    (out_count),
    .out_all_zero (out_all_zero),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_lz(input logic [31:0] d);
    int n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) return n;
      n++;
    end
    return n;
  endfunction

  function automatic int ref_lat(input int lz);
    if (lz >= 32) return 4;
    return lz / 8 + 1;
  endfunction

  // Stimulus helper: present one word, return latency (edges after accept) and result.
  task automatic do_word(input logic [31:0] d, output int lat,
                         output logic [5:0] cnt, output logic az);
    int g;
    g   = 0;
    lat = -1;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    cnt = out_count;
    az  = out_all_zero;
  endtask

  task automatic test_reset();
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        out_count !== 6'd0 || out_all_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b busy=%b ov=%b cnt=%0d az=%b, want 1 0 0 0 0",
               in_ready, busy, out_valid, out_count, out_all_zero);
    end
  endtask

  task automatic test_basic();
    int lat; logic [5:0] c; logic az;
    out_ready = 1'b1;
    do_word(32'h00000000, lat, c, az);
    tests++;
    if (lat !== 4 || c !== 6'd32 || az !== 1'b1) begin
      fails++;
      $display("FAIL all_zero: got lat=%0d cnt=%0d az=%b, want 4 32 1", lat, c, az);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL one_cycle_valid: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    do_word(32'h80000000, lat, c, az);
    tests++;
    if (lat !== 1 || c !== 6'd0 || az !== 1'b0) begin
      fails++;
      $display("FAIL msb_set: got lat=%0d cnt=%0d az=%b, want 1 0 0", lat, c, az);
    end
    do_word(32'h00010000, lat, c, az);
    tests++;
    if (lat !== 2 || c !== 6'd15 || az !== 1'b0) begin
      fails++;
      $display("FAIL chunk2: got lat=%0d cnt=%0d az=%b, want 2 15 0", lat, c, az);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    int g;
    out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b1;
    in_data  = 32'h00000001;
    @(posedge clk); #1;
    in_data = 32'h00F00000;
    lat = -1;
    for (int n = 1; n <= 4; n++) begin
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL b2b_ready_low: cycle %0d got rdy=%b, want 0", n, in_ready);
      end
      @(posedge clk); #1;
      if (out_valid && lat < 0) lat = n;
    end
    tests++;
    if (lat !== 4 || out_count !== 6'd31 || out_all_zero !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got lat=%0d cnt=%0d az=%b, want 4 31 0", lat, out_count, out_all_zero);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready_done: got rdy=%b, want 0", in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready_idle: got rdy=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    tests++;
    if (lat !== 2 || out_count !== 6'd8 || out_all_zero !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: got lat=%0d cnt=%0d az=%b, want 2 8 0", lat, out_count, out_all_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [5:0] c; logic az;
    out_ready = 1'b0;
    do_word(32'h0000FF00, lat, c, az);
    tests++;
    if (lat !== 3 || c !== 6'd16 || az !== 1'b0) begin
      fails++;
      $display("FAIL bp_result: got lat=%0d cnt=%0d az=%b, want 3 16 0", lat, c, az);
    end
    for (int n = 0; n < 5; n++) begin
      in_valid = n[0];
      in_data  = 32'hFFFFFFFF;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_count !== 6'd16 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: cycle %0d got ov=%b cnt=%0d rdy=%b, want 1 16 0",
                 n, out_valid, out_count, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [5:0] c; logic az;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h00000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b rdy=%b ov=%b, want 0 1 0", busy, in_ready, out_valid);
    end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    do_word(32'h00000100, lat, c, az);
    tests++;
    if (lat !== 3 || c !== 6'd23 || az !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: got lat=%0d cnt=%0d az=%b, want 3 23 0", lat, c, az);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat; logic [5:0] c; logic az;
    logic [31:0] d;
    int exp_lz;
    out_ready = 1'b1;
    for (int i = 0; i < 1033; i++) begin
      if (i < 33) d = (i == 32) ? 32'h0 : (32'h1 << i);
      else        d = $urandom >> $urandom_range(0, 31);
      exp_lz = ref_lz(d);
      do_word(d, lat, c, az);
      tests++;
      if (lat !== ref_lat(exp_lz) || int'(c) !== exp_lz || az !== (exp_lz == 32)) begin
        fails++;
        $display("FAIL sweep %h: got lat=%0d cnt=%0d az=%b, want %0d %0d %b",
                 d, lat, c, az, ref_lat(exp_lz), exp_lz, (exp_lz == 32));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lzc_seq_ctrl.md
Name: lzc_seq_ctrl

Overview:
- Multi-cycle leading-zero counter for a wide word.
- Holds one internal zero_counter instance (DATA_W-bit chunk, MSB-first zero count) and feeds it CHUNKS chunks of the input, one per cycle, MSB chunk first.
- Accumulates the per-chunk counts and stops early at the first chunk that contains a 1.
- Uses a valid/ready handshake on both the input and output sides. Sits ahead of normalisation/shift logic that needs a leading-zero count of a wide operand.

Parameters:
- DATA_W, 8, chunk width; the DATA_W parameter of the internal zero_counter.
- CHUNKS, 4, number of chunks; full word width W = DATA_W*CHUNKS (default 32).
- ZC_W, 4, count width of the internal zero_counter; must satisfy ZC_W >= clog2(DATA_W+1).
- COUNT_W, 6, result width; must satisfy COUNT_W >= clog2(W+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word; combinational, equals (state==IDLE).
- in_data  in  W  word to count; bit W-1 is the MSB.
- out_valid  out  1  result is valid; registered.
- out_ready  in  1  consumer accepts the result.
- out_count  out  COUNT_W  number of leading zeros, 0..W; registered.
- out_all_zero  out  1  high when out_count==W; registered.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-scan):
  - state=IDLE, shift register=0, accumulator=0, chunk index=0.
  - out_valid=0, out_count=0, out_all_zero=0.
  - in_ready=1 and busy=0 immediately.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the shift register, clear the accumulator, set idx=0, go to SCAN.
- SCAN (each cycle):
  - chunk = shift register top DATA_W bits; zc = zero_counter(chunk), zero-extended to COUNT_W.
  - On the edge: acc_next = acc + zc.
  - If zc < DATA_W (chunk has a 1) or idx == CHUNKS-1:
    - out_count <= acc_next, out_all_zero <= (acc_next==W), out_valid <= 1.
    - Go to DONE.
  - Otherwise: shift the register left by DATA_W (zero-fill), idx++, stay in SCAN.
  - Early exit: chunks after the first non-zero chunk are never examined.
- DONE:
  - out_valid, out_count and out_all_zero hold stable until out_valid&&out_ready.
  - On that edge: out_valid <= 0, go to IDLE. out_count keeps its last value (don't-care while out_valid=0).
- Latency:
  - Let k be the 1-based index of the first non-zero chunk (k=CHUNKS if all chunks are zero).
  - out_valid rises k rising edges after the accepting edge; 1 <= k <= CHUNKS.
- Throughput: no overlap.
  - in_ready is 0 in SCAN and DONE, including the cycle in which out_ready completes the output handshake.
  - The next accept is possible no earlier than the cycle after the return to IDLE.
- in_valid/in_data are ignored while in_ready=0. in_data may change freely after the accept edge.
- Arithmetic:
  - The accumulator is COUNT_W wide. With the parameter constraints it cannot overflow.
  - Maximum value is W, reached only when every chunk is zero.
- out_ready may be held high permanently. The result is then consumed in the first DONE cycle (out_valid high for exactly 1 cycle).

Test Plan:
- Defaults, in_data=32'h00000000, out_ready=1 -> out_valid 4 edges after accept, out_count=32, out_all_zero=1, out_valid high 1 cycle.
- in_data=32'h80000000 -> latency 1, out_count=0, out_all_zero=0. Then 32'h00010000 -> latency 2, out_count=15.
- Back-to-back: in_valid held high with 32'h00000001 then 32'h00F00000:
  - First result: latency 4, count=31.
  - in_ready stays 0 from the accept until the cycle after the output handshake.
  - Second word is accepted only then; result latency 2, count=8.
- Backpressure: in_data=32'h0000FF00, out_ready=0 for 5 cycles after out_valid rises:
  - out_valid=1, out_count=16 stable for all 5 cycles.
  - in_ready=0; in_valid pulses are ignored.
  - After out_ready=1, out_valid drops on the next edge.
- Reset mid-operation: accept 32'h00000000, assert rst asynchronously (between edges) during the 2nd SCAN cycle:
  - busy=0, in_ready=1, out_valid=0 immediately.
  - After deassertion, 32'h00000100 yields latency 3, count=23.
- Exhaustive check: 1000 random words plus all 33 single-bit/zero patterns, compared against a reference leading-zero model.
  - out_count and latency k must match.
  - out_all_zero must equal (out_count==32).
